// File: rtl/bus_timer.sv
// rtl/bus_timer.sv - memory-mapped machine timer responder (MTIME/MTIMECMP/CTRL/PRESCALE/STATUS)
module bus_timer #(
    parameter logic [63:0] BASE_ADDR        = 64'h0000_0000_2000_0000,
    parameter logic [31:0] DEFAULT_PRESCALE = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] addr,
    input  logic [2:0]  rd_ctrl,
    input  logic [2:0]  wr_ctrl,
    input  logic [63:0] data_in,
    output logic [63:0] data_out,
    output logic        valid,
    output logic        timer_irq
);

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic [31:0] prescale_q, prescale_d;
    logic [31:0] pcnt_q, pcnt_d;
    logic        pend_q, pend_d;
    logic        irq_q, irq_d;
    logic [63:0] data_q, data_d;
    logic        valid_q, valid_d;

    logic        hit;
    logic [2:0]  lane;
    logic [8:0]  sel;
    logic        w_act, r_act;
    logic [1:0]  w_size, r_size;
    logic        w_ok;
    logic [7:0]  bmask;
    logic [63:0] bitmask;
    logic [63:0] wdata;
    logic        we_mtime, we_cmp, we_ctrl, we_pre, we_stat;
    logic        tick, cmp, w1c;
    logic [63:0] rreg, rsh, rext;

    // Natural alignment: the low address bits covered by the access size must be zero.
    function automatic logic is_aligned(input logic [1:0] sz, input logic [2:0] ln);
        case (sz)
            2'd0:    return 1'b1;
            2'd1:    return ~ln[0];
            2'd2:    return ln[1:0] == 2'b00;
            default: return ln == 3'b000;
        endcase
    endfunction

    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    assign hit  = (addr[63:12] == BASE_ADDR[63:12]);
    assign lane = addr[2:0];
    assign sel  = addr[11:3];

    // Decode access sizes from the load/store encodings.
    always_comb begin
        w_act  = 1'b1;
        w_size = 2'd0;
        case (wr_ctrl)
            3'd1:    w_size = 2'd0;
            3'd2:    w_size = 2'd1;
            3'd3:    w_size = 2'd2;
            3'd4:    w_size = 2'd3;
            default: w_act = 1'b0;
        endcase
        r_act  = (rd_ctrl != 3'd0);
        case (rd_ctrl)
            3'd3, 3'd4: r_size = 2'd1;
            3'd5, 3'd6: r_size = 2'd2;
            3'd7:       r_size = 2'd3;
            default:    r_size = 2'd0;
        endcase
    end

    // Byte-enable mask and lane-shifted store data for the addressed register.
    always_comb begin
        w_ok  = hit & w_act & is_aligned(w_size, lane);
        bmask = size_mask(w_size) << lane;
        for (int i = 0; i < 8; i++) begin
            bitmask[i*8 +: 8] = {8{bmask[i]}};
        end
        wdata    = data_in << {lane, 3'b000};
        we_mtime = w_ok & (sel == 9'd0);
        we_cmp   = w_ok & (sel == 9'd1);
        we_ctrl  = w_ok & (sel == 9'd2);
        we_pre   = w_ok & (sel == 9'd3);
        we_stat  = w_ok & (sel == 9'd4);
    end

    // Counter, compare and register write next-state; a bus write to MTIME suppresses the tick.
    always_comb begin
        tick   = ctrl_q[0] & (pcnt_q == prescale_q);
        pcnt_d = pcnt_q;
        if (ctrl_q[0]) begin
            pcnt_d = tick ? 32'd0 : pcnt_q + 32'd1;
        end
        if (we_pre) begin
            pcnt_d = 32'd0;
        end
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        if (we_mtime) begin
            mtime_d = (mtime_q & ~bitmask) | (wdata & bitmask);
        end
        mtimecmp_d = we_cmp ? ((mtimecmp_q & ~bitmask) | (wdata & bitmask)) : mtimecmp_q;
        ctrl_d     = we_ctrl ? ((ctrl_q & ~bitmask[1:0]) | (wdata[1:0] & bitmask[1:0])) : ctrl_q;
        prescale_d = we_pre ? ((prescale_q & ~bitmask[31:0]) | (wdata[31:0] & bitmask[31:0]))
                            : prescale_q;
        cmp    = (mtime_q >= mtimecmp_q);
        w1c    = we_stat & bmask[0] & wdata[0];
        pend_d = cmp | (pend_q & ~w1c);
        irq_d  = pend_q & ctrl_q[1];
    end

    // Read path: select register from pre-update state, shift lane down, extend per load type.
    always_comb begin
        case (sel)
            9'd0:    rreg = mtime_q;
            9'd1:    rreg = mtimecmp_q;
            9'd2:    rreg = {62'd0, ctrl_q};
            9'd3:    rreg = {32'd0, prescale_q};
            9'd4:    rreg = {63'd0, pend_q};
            default: rreg = 64'd0;
        endcase
        rsh = rreg >> {lane, 3'b000};
        case (rd_ctrl)
            3'd1:    rext = {{56{rsh[7]}}, rsh[7:0]};
            3'd2:    rext = {56'd0, rsh[7:0]};
            3'd3:    rext = {{48{rsh[15]}}, rsh[15:0]};
            3'd4:    rext = {48'd0, rsh[15:0]};
            3'd5:    rext = {{32{rsh[31]}}, rsh[31:0]};
            3'd6:    rext = {32'd0, rsh[31:0]};
            default: rext = rsh;
        endcase
        valid_d = hit & r_act;
        data_d  = data_q;
        if (valid_d) begin
            data_d = is_aligned(r_size, lane) ? rext : 64'd0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_q    <= 64'd0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            ctrl_q     <= 2'd0;
            prescale_q <= DEFAULT_PRESCALE;
            pcnt_q     <= 32'd0;
            pend_q     <= 1'b0;
            irq_q      <= 1'b0;
            data_q     <= 64'd0;
            valid_q    <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            pend_q     <= pend_d;
            irq_q      <= irq_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
        end
    end

    assign data_out  = data_q;
    assign valid     = valid_q;
    assign timer_irq = irq_q;

endmodule
